// File: rtl/interrupt_controller_if.sv
// Bus bundle between the CPU-side master and the interrupt controller:
// raw IRQ lines, control-unit handshake, config register port and trap outputs.
interface interrupt_controller_if #(
  parameter int NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq_in;
  logic               int_ack;
  logic               eret;
  logic [31:0]        pc_in;
  logic               cfg_we;
  logic [1:0]         cfg_sel;
  logic [31:0]        cfg_wdata;
  logic [31:0]        cfg_rdata;
  logic               int_req;
  logic               in_service;
  logic [31:0]        epc;
  logic [2:0]         cause;
  logic [31:0]        vector_addr;

  modport master (
    output irq_in, int_ack, eret, pc_in, cfg_we, cfg_sel, cfg_wdata,
    input  cfg_rdata, int_req, in_service, epc, cause, vector_addr
  );

  modport slave (
    input  irq_in, int_ack, eret, pc_in, cfg_we, cfg_sel, cfg_wdata,
    output cfg_rdata, int_req, in_service, epc, cause, vector_addr
  );
endinterface

// File: rtl/interrupt_controller.sv
// Edge-latched, masked, fixed-priority interrupt controller for the multicycle MIPS core.
// Optional periodic timer on the lowest-priority line: define IH_TIMER_EN.
module interrupt_controller #(
  parameter int          NUM_IRQ      = 4,
  parameter logic [31:0] VECTOR_BASE  = 32'h0000_0100,
  parameter logic [15:0] TIMER_PERIOD = 16'd1000
) (
  input logic              clock,
  input logic              reset,
  interrupt_controller_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]         state;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] enabled;
  logic [NUM_IRQ-1:0] ack_bit;
  logic [NUM_IRQ-1:0] cfg_clr;
  logic [2:0]         cause_next;
  logic               take_ack;
  logic [31:0]        epc;
  logic [2:0]         cause;
  logic [15:0]        timer_count;
  logic               timer_pulse;
  logic               unused_wdata;

`ifdef IH_TIMER_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    timer_count <= TIMER_PERIOD - 16'd1;
    else if (timer_count == 16'd0) timer_count <= TIMER_PERIOD - 16'd1;
    else                          timer_count <= timer_count - 16'd1;
  end
  assign timer_pulse = (timer_count == 16'd0);
`else
  logic unused_period;
  assign timer_count   = '0;
  assign timer_pulse   = 1'b0;
  assign unused_period = ^TIMER_PERIOD;
`endif

  assign unused_wdata = ^bus.cfg_wdata[31:NUM_IRQ];

  // The timer pulse looks like one extra rising edge on the lowest-priority line.
  assign rise    = (bus.irq_in & ~irq_prev) | {timer_pulse, {(NUM_IRQ-1){1'b0}}};
  assign enabled = pending & mask;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cause_next = '0;
    ack_bit    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (enabled[i]) begin
        cause_next = 3'(i);
        ack_bit    = '0;
        ack_bit[i] = 1'b1;
      end
    end
  end

  assign take_ack = (state == ST_REQ) && bus.int_ack && (|enabled);
  assign cfg_clr  = (bus.cfg_we && bus.cfg_sel == 2'd1) ? bus.cfg_wdata[NUM_IRQ-1:0] : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_prev <= '0;
      pending  <= '0;
      mask     <= '0;
      epc      <= '0;
      cause    <= '0;
    end else begin
      irq_prev <= bus.irq_in;
      // A new edge wins over a clear of the same bit, from either source.
      pending  <= (pending & ~(cfg_clr | (take_ack ? ack_bit : '0))) | rise;
      if (bus.cfg_we && bus.cfg_sel == 2'd0) mask <= bus.cfg_wdata[NUM_IRQ-1:0];
      if (take_ack) begin
        epc   <= bus.pc_in;
        cause <= cause_next;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (|enabled) state <= ST_REQ;
        ST_REQ: begin
          if (!(|enabled))     state <= ST_IDLE;
          else if (bus.int_ack) state <= ST_SERVICE;
        end
        ST_SERVICE: if (bus.eret) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign bus.int_req     = (state == ST_REQ);
  assign bus.in_service  = (state == ST_SERVICE);
  assign bus.epc         = epc;
  assign bus.cause       = cause;
  assign bus.vector_addr = VECTOR_BASE + {26'b0, cause, 3'b000};

  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_sel)
      2'd0:    bus.cfg_rdata = 32'(mask);
      2'd1:    bus.cfg_rdata = 32'(pending);
      2'd2:    bus.cfg_rdata = {28'b0, state == ST_SERVICE, cause};
      default: bus.cfg_rdata = 32'(timer_count);
    endcase
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Collects external interrupt lines for the multicycle MIPS core, latches them as pending, masks and prioritises them, and raises a request to the control unit. On the control unit's acknowledge at an instruction boundary, it captures the return PC (EPC) and cause, and produces the handler vector for the PC source mux. It sits directly upstream of the control unit and PC mux, and is configured by CPU stores through a small register port.

## Interface
- NUM_IRQ, 4, number of interrupt lines (2..8); line 0 highest priority
- VECTOR_BASE, 32'h0000_0100, handler base address
- TIMER_PERIOD, 16'd1000, timer reload period in cycles (only with IH_TIMER_EN)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- irq_in  in  NUM_IRQ  raw interrupt lines, rising-edge sensitive
- int_ack  in  1  control unit accepts request (1-cycle pulse)
- eret  in  1  control unit finished handler (1-cycle pulse)
- pc_in  in  32  PC to resume at, sampled on int_ack
- cfg_we  in  1  register write strobe
- cfg_sel  in  2  0=mask, 1=pending, 2=status
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  read data, combinational from cfg_sel
- int_req  out  1  registered request to the control unit
- in_service  out  1  handler active
- epc  out  32  captured return PC
- cause  out  3  index of the serviced line
- vector_addr  out  32  VECTOR_BASE + cause*8

## Operation
- Edge detect: irq_prev register per line. Rising edge = irq_in & ~irq_prev. Each rising edge sets the matching pending bit.
- mask register (NUM_IRQ bits):
  - Write with cfg_sel=0 loads cfg_wdata[NUM_IRQ-1:0].
  - A bit of 1 enables that line.
- pending: write with cfg_sel=1 clears every bit where cfg_wdata is 1 (write-1-to-clear).
- status read (cfg_sel=2): {28'b0, in_service, cause}. Writes to status are ignored.
- cfg_sel=3 reads zero; writes are ignored.
- Unused cfg_rdata bits read zero.
- FSM has three states: IDLE, REQ, SERVICE.
  - IDLE→REQ when |(pending & mask).
  - REQ→IDLE when (pending & mask)==0, i.e. masked or cleared before ack.
  - REQ→SERVICE on int_ack:
    - epc←pc_in.
    - cause←lowest set index of pending&mask.
    - That pending bit is cleared.
  - SERVICE→IDLE on eret.
- Outputs per state: int_req=1 only in REQ. in_service=1 only in SERVICE.
- No nesting. In SERVICE, new edges still set pending but no request is raised until IDLE.
- Ignored pulses: int_ack outside REQ; eret outside SERVICE.
- Simultaneous events:
  - Set beats clear on the same pending bit, whether the clear comes from ack or from a cfg write.
  - If eret and a pending enabled line coincide: SERVICE→IDLE this edge, then →REQ on the next edge.
- epc, cause and vector_addr hold their values until the next ack. Reset does clear them.
- Reset clears everything (async): state=IDLE, pending, mask, irq_prev, epc, cause all zero. vector_addr=VECTOR_BASE, cfg_rdata=0 (cfg_sel=0).

## Timing
- Detection latency: irq_in low at edge k-1 and high at edge k → pending set after edge k.
- Request latency: int_req rises after edge k+1 if the line is enabled, i.e. 2 cycles from first sampling.
- Ack: epc, cause, vector_addr and in_service are valid after the ack edge. int_req falls the same edge.
- cfg write: takes effect at the edge where cfg_we=1. A mask change affects the FSM on the following edge.
- A level held high produces exactly one pending set. It must go low and high again to re-trigger.

## Configuration
- IH_TIMER_EN defined:
  - A 16-bit down-counter reloads TIMER_PERIOD-1 after reset and on reaching 0.
  - At 0 it emits a 1-cycle pulse that is treated as a rising edge on line NUM_IRQ-1 (lowest priority), OR-ed with irq_in[NUM_IRQ-1].
  - cfg_sel=3 reads the current count.
- IH_TIMER_EN undefined: no counter exists. Line NUM_IRQ-1 comes from irq_in only, and cfg_sel=3 reads zero.

## Test plan
- Reset with irq_in=4'b1111 held → int_req=0, pending=0, epc=0, vector_addr=32'h100. After release, mask=0 keeps int_req=0 while pending reads 4'hF.
- mask=4'b0110, rising edges on lines 1 and 2 in the same cycle, ack with pc_in=32'h0040_0020:
  - cause=1, epc=32'h0040_0020, vector_addr=32'h108, pending=4'b0100.
  - After eret, int_req reasserts 2 edges later (cause 2 on the next ack).
- Line 3 pending and enabled, int_req=1, then mask cleared to 0 before ack → int_req drops on the next edge. Ack pulses while in IDLE change nothing.
- In SERVICE, edge on line 0 → pending[0]=1 and int_req stays 0. eret → int_req=1 one edge later.
- Same-cycle set and clear: cfg write-1-to-clear of pending[2] while line 2 rises → pending[2]=1.
- With IH_TIMER_EN and TIMER_PERIOD=10, mask=4'b1000:
  - int_req asserts every 10 cycles while not in service.
  - Async reset mid-SERVICE → IDLE, count reloads to 9.
